// File: rtl/bcd_7seg_scan_driver.sv
// rtl/bcd_7seg_scan_driver.sv - multiplexed BCD to common-anode seven-segment scan driver
// Optional leading-zero blanking when BCD_SCAN_LZB_EN is defined.
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [3:0]              w_digit;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic                    w_cnt_wrap;
    logic                    w_zero_above;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign w_cnt_wrap = (r_cnt == CNT_MAX);

    always_comb begin
        w_digit      = 4'd0;
        w_blank      = 1'b0;
        w_zero_above = 1'b1;
        w_an_next    = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_above = w_zero_above & (r_shadow[4*k +: 4] == 4'd0);
            if (r_idx == IDX_W'(k)) begin
                w_digit = r_shadow[4*k +: 4];
`ifdef BCD_SCAN_LZB_EN
                w_blank = (k >= 1) && w_zero_above;
`else
                w_blank = 1'b0;
`endif
            end
            // cnt == 0 is the dead-time slot: every anode stays off
            w_an_next[k] = ~((r_cnt != '0) && (r_idx == IDX_W'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            seg_n      <= 7'b1111111;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= bcd_in;
            end
            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            seg_n      <= w_blank ? 7'b1111111 : seg_decode(w_digit);
            an_n       <= w_an_next;
            frame_tick <= w_cnt_wrap && (r_idx == IDX_MAX);
        end
    end
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// tb/tb_bcd_7seg_scan_driver.sv - randomized bench with cycle-count reference model
module tb_bcd_7seg_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] bcd_in = '0;
    logic [6:0]      seg_n;
    logic [ND-1:0]   an_n;
    logic            frame_tick;

    bcd_7seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
        .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int sh[ND];
    int ticks;
    logic [6:0] dec[16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F,
                            7'h7F, 7'h7F, 7'h7F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit blanked(input int k);
        bit b;
        b = 1'b0;
`ifdef BCD_SCAN_LZB_EN
        if (k >= 1) begin
            b = 1'b1;
            for (int j = k; j < ND; j++) if (sh[j] != 0) b = 1'b0;
        end
`endif
        return b;
    endfunction

    // One clock: expectations come from the number of edges since reset
    task automatic step(input logic ld, input logic [4*ND-1:0] val);
        int cnt, idx;
        logic [ND-1:0] e_an;
        logic [6:0] e_seg;
        logic e_tick;
        load = ld;
        bcd_in = val;
        @(posedge clk);
        cnt = n % SD;
        idx = (n / SD) % ND;
        e_an = (cnt == 0) ? {ND{1'b1}} : ~(ND'(1) << idx);
        e_seg = blanked(idx) ? 7'h7F : dec[sh[idx]];
        e_tick = (cnt == SD - 1) && (idx == ND - 1);
        if (ld) for (int k = 0; k < ND; k++) sh[k] = int'(val[4*k +: 4]);
        n++;
        #1;
        load = 1'b0;
        check_eq("an_n", 32'(an_n), 32'(e_an));
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (frame_tick) ticks++;
    endtask

    task automatic align(input int modulo, input int phase);
        int guard = 0;
        while ((n % modulo) != phase && guard < 64) begin
            step(1'b0, '0);
            guard++;
        end
    endtask

    task automatic frame_with(input logic [4*ND-1:0] val);
        align(ND * SD, 0);
        step(1'b1, val);
        ticks = 0;
        for (int c = 0; c < ND * SD; c++) step(1'b0, '0);
        check_eq("ticks_per_frame", 32'(ticks), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < ND; k++) sh[k] = 0;
        #12;
        check_eq("rst_seg", 32'(seg_n), 32'h7F);
        check_eq("rst_an", 32'(an_n), 32'hF);
        check_eq("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        step(1'b0, '0);
        check_eq("first_an", 32'(an_n), 32'hF);
        step(1'b0, '0);
        check_eq("second_an", 32'(an_n), 32'hE);
        check_eq("second_seg", 32'(seg_n), 32'(7'b0000001));

        frame_with(16'h1234);
        frame_with(16'h9AF0);
        frame_with(16'h0050);
        frame_with(16'h0000);

        // Asynchronous reset mid-frame at idx 2, cnt 3
        align(ND * SD, 2 * SD + 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_seg", 32'(seg_n), 32'h7F);
        check_eq("mid_rst_an", 32'(an_n), 32'hF);
        check_eq("mid_rst_tick", 32'(frame_tick), 32'd0);
        n = 0;
        for (int k = 0; k < ND; k++) sh[k] = 0;
        #2 rst_n = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        check_eq("restart_seg", 32'(seg_n), 32'(7'b0000001));
        check_eq("restart_an", 32'(an_n), 32'hE);

        // Load coincident with digit advance
        step(1'b1, 16'h8888);
        align(SD, SD - 1);
        step(1'b1, 16'h1357);
        for (int c = 0; c < SD + 1; c++) step(1'b0, '0);

        for (int c = 0; c < 600; c++) begin
            logic [4*ND-1:0] v;
            for (int k = 0; k < ND; k++)
                v[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 7) == 0, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_7seg_scan_driver.md
# bcd_7seg_scan_driver

Multi-digit, time-multiplexed BCD to seven-segment display driver. It generalises the single-digit BCD decoder to NUM_DIGITS digits sharing one segment bus. It adds a load-strobed shadow register, a programmable refresh prescaler, a dead-time slot between digits, and a frame tick. It sits between the counter/arithmetic datapath blocks and the board-level common-anode display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 1000: clock cycles each digit occupies per scan; legal minimum 2.

- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  when high at a clk edge, bcd_in is captured into the shadow register.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit k at bits [4k+3:4k]; digit 0 is least significant.
- seg_n  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a; active-low (0 = lit); registered.
- an_n  output  NUM_DIGITS  digit enables; active-low, at most one bit low; registered.
- frame_tick  output  1  one-cycle pulse per completed scan frame; registered.

## Operation
- Shadow register: NUM_DIGITS×4 bits. It is written only on load. The display always reads the shadow register, never bcd_in directly.
- Prescaler cnt counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and digit index idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Decode (active-low) for digit values 0..9:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Values 10..15 decode to 1111111 (digit dark).
- Next-value rules for the registered outputs, evaluated from the pre-edge cnt, idx and shadow:
  - an_n: all ones when cnt == 0 (dead-time slot, anti-ghosting). Otherwise bit idx is low and all other bits are high.
  - seg_n: decode(shadow[idx]), or 1111111 when that digit is blanked (see Configuration).
  - frame_tick: 1 when cnt == SCAN_DIV-1 and idx == NUM_DIGITS-1; otherwise 0.
- If load and a digit change occur on the same edge, the scan proceeds unaffected. The new shadow value is seen from the following edge onward, so no digit ever shows a mix of old and new segments within a single cycle.
- With NUM_DIGITS = 1, idx stays at 0 and frame_tick pulses once every SCAN_DIV cycles.

## Timing
- Reset (asynchronous assert, synchronous release) clears:
  - cnt = 0, idx = 0, shadow = all zeros
  - seg_n = 1111111, an_n = all ones, frame_tick = 0
- Output latency: one cycle from state to pins. Each digit is dark for 1 cycle and lit for SCAN_DIV-1 cycles.
- Full frame period: NUM_DIGITS×SCAN_DIV cycles.
- Load-to-display latency:
  - The shadow register updates at the load edge.
  - The pins reflect the new value at the next edge, provided the currently scanned digit is lit.
- Reset asserted mid-frame: outputs go to reset values immediately. Scanning restarts from digit 0 at cnt = 0.
- The prescaler width is ceil(log2(SCAN_DIV)) bits. No other arithmetic is performed.

## Configuration
- BCD_SCAN_LZB_EN: leading-zero blanking.
  - Defined: digit k (k ≥ 1) is blanked when shadow digit k and every more-significant digit all equal 0. Digit 0 is never blanked. Values 10..15 count as non-zero. A blanked digit drives seg_n = 1111111 while its an_n bit still follows the scan.
  - Undefined: no blanking; every digit shows its decode.

## Test plan
- Reset with NUM_DIGITS = 4, SCAN_DIV = 4: hold rst_n low, then release.
  - seg_n = 7F and an_n = F while in reset.
  - First post-release edge: an_n = F.
  - Next edge: an_n = E, seg_n = 0000001.
- load 0x1234, observe one frame:
  - an_n sequence per digit is F, E, E, E, F, D, D, D, F, B, B, B, F, 7, 7, 7.
  - seg_n in the lit slots is 1001100, 0000110, 0010010, 1001111.
  - frame_tick is high for exactly 1 of every 16 cycles.
- load 0x9AF0: digits 1 and 2 show 1111111 while their an_n bits go low; digit 3 shows 0000100.
- With BCD_SCAN_LZB_EN defined, load 0x0050:
  - Digits 3 and 2 are blank; digits 1 and 0 show 0100100 and 0000001.
  - load 0x0000 then leaves only digit 0 lit, showing 0000001.
- Pulse rst_n low while idx = 2, cnt = 3: outputs clear asynchronously and shadow clears. After release the scan restarts at digit 0 showing 0000001.
- Pulse load at the same edge where idx advances: the outgoing digit shows the old value through that edge. The new digit shows the new value from its first lit cycle.
